regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port (`reg_write`/`A3`/`WD3`) between two writeback sources. The primary source is the single-cycle ALU/load path. The secondary source is a multi-cycle unit (divider, CSR/bus reads). The secondary result is held in a one-entry buffer until the write port is free, with a starvation bound and same-register ordering. The block sits between the execute/writeback stage and `regfile`, and exports a busy indication that decode uses to stall.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles a buffered secondary entry may be denied before it preempts the primary; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_valid`  in  1  primary writeback request.
- `p_rd`  in  5  primary destination register.
- `p_data`  in  32  primary write data.
- `p_ready`  out  1  primary write accepted this cycle.
- `s_valid`  in  1  secondary writeback request.
- `s_rd`  in  5  secondary destination register.
- `s_data`  in  32  secondary write data.
- `s_ready`  out  1  buffer can capture the secondary request this cycle.
- `reg_write`  out  1  write enable to the register file.
- `A3`  out  5  write address to the register file.
- `WD3`  out  32  write data to the register file.
- `hold_valid`  out  1  buffer holds an unwritten secondary result.
- `hold_rd`  out  5  destination of the held result; decode stalls readers or writers of this register.

## Operation
- Two states: EMPTY (no buffered entry) and HELD (entry `{hold_rd, hold_data}` valid). `hold_valid` = (state == HELD).
- Secondary handshake: capture on `s_valid && s_ready`. EMPTY→HELD on capture.
- `s_ready` = EMPTY, or HELD with the buffer draining this cycle. A simultaneous drain and capture stays in HELD and holds the new entry.
- Grant, evaluated each cycle in priority order:
  1. In HELD with `starve_cnt == STARVE_LIMIT`: the buffer is granted and `p_ready` = 0.
  2. In HELD with `p_valid` and `p_rd == hold_rd` (same-register collision): the buffer is granted and `p_ready` = 0. The older result writes first; the primary writes the next cycle.
  3. If `p_valid` with `p_rd == 0`: the primary is consumed (`p_ready` = 1) without using the port, and the buffer, if HELD, is granted the port.
  4. If `p_valid`: the primary is granted (`p_ready` = 1).
  5. In HELD otherwise: the buffer is granted.
- When the primary is not granted, `p_ready` = 0 and the primary holds its request.
- Port drive:
  - Primary granted: `A3 = p_rd`, `WD3 = p_data`.
  - Buffer granted: `A3 = hold_rd`, `WD3 = hold_data`.
  - `reg_write` = grant && `A3 != 0`.
  - Idle: `reg_write` = 0, `A3` = 0, `WD3` = 0.
- Buffer granted means drained: HELD→EMPTY, unless a new capture happens in the same cycle.
- Secondary requests with `s_rd == 0` are captured normally. They are drained without asserting `reg_write`.
- `starve_cnt` (4 bits):
  - Cleared in EMPTY and on every drain.
  - Incremented each HELD cycle in which the buffer is not granted.
  - Saturates at `STARVE_LIMIT`.

## Timing
- Primary latency: 0 cycles. The write port is driven combinationally, and the register file commits it at the next edge.
- Secondary latency: at least 1 cycle from capture to write, and at most `STARVE_LIMIT` + 1 cycles under continuous primary traffic.
- Secondary throughput: 1 entry per cycle when the port is free, via back-to-back drain and capture.
- Reset: state EMPTY, `starve_cnt` = 0, hold registers = 0.
  - While `reset` is high, `reg_write`, `p_ready` and `s_ready` = 0, `hold_valid` = 0, and `hold_rd` = 0.
  - Reset mid-operation discards the held entry with no write.
- `p_ready` and `s_ready` depend combinationally on `p_valid`/`p_rd`. Neither depends on `s_valid`, so there is no combinational loop with the secondary unit.

## Structure
- Shared package `cpu_pkg`:
  - `regaddr_t` (5 bits) and `word_t` (32 bits).
  - `wb_req_t {rd, data}`.
  - Constant `REG_ZERO = 5'd0`.
- Local enum `{EMPTY, HELD}`.
- One natural sub-module: `wb_hold_buf`, the one-entry valid/ready buffer with capture/drain. Arbitration and the starvation counter stay in the top module.

## Test plan
- Primary only: `p_valid=1`, `p_rd=5`, `p_data=0xDEADBEEF`, with EMPTY → same cycle `reg_write=1`, `A3=5`, `WD3=0xDEADBEEF`, `p_ready=1`.
- Secondary capture and idle drain: `s_valid=1`, `s_rd=7`, `s_data=0x11` for one cycle, then idle → next cycle `reg_write=1`, `A3=7`, `WD3=0x11`, then `hold_valid=0`.
- Starvation:
  - Stimulus: HELD (`rd=9`) with `p_valid=1` continuously (`rd≠9`, `STARVE_LIMIT=4`).
  - Response: the primary wins 4 cycles; the 5th cycle writes `rd=9` with `p_ready=0`; the primary resumes in the 6th cycle.
- Collision and x0:
  - HELD `rd=3` with primary `rd=3` → buffer writes first (`p_ready=0`), the primary's `rd=3` write follows next cycle.
  - Primary `rd=0` alongside HELD `rd=4` → `p_ready=1` and `A3=4` written the same cycle.
- Simultaneous drain/capture: HELD and idle primary with `s_valid=1`, `s_rd=8` → old entry written, `s_ready=1`, and `hold_rd=8` after the edge.
- Reset mid-operation: assert `reset` while HELD → `reg_write=0` and no write; after release, `hold_valid=0` and `starve_cnt=0`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file writeback types and constants
package cpu_pkg;
  typedef logic [4:0] regaddr_t;
  typedef logic [31:0] word_t;
  typedef struct packed {
    regaddr_t rd;
    word_t    data;
  } wb_req_t;
  localparam regaddr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_hold_buf.sv
// wb_hold_buf: one-entry secondary writeback buffer with capture/drain
module wb_hold_buf
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    cap,
  input  logic    drain,
  input  wb_req_t cap_req,
  output logic    hold_valid,
  output wb_req_t hold
);
  typedef enum logic {EMPTY, HELD} state_t;
  state_t state_q, state_d;
  // state register; reset discards any held entry
  always_ff @(posedge clk) state_q <= reset ? EMPTY : state_d;
  // a capture always lands in HELD, even when the old entry drains the same cycle
  always_comb state_d = cap ? HELD : (drain ? EMPTY : state_q);
  // entry payload, loaded on capture
  always_ff @(posedge clk)
    if (reset) hold <= '0;
    else if (cap) hold <= cap_req;
  assign hold_valid = state_q == HELD;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between primary and buffered secondary writeback
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     p_valid,
  input  regaddr_t p_rd,
  input  word_t    p_data,
  output logic     p_ready,
  input  logic     s_valid,
  input  regaddr_t s_rd,
  input  word_t    s_data,
  output logic     s_ready,
  output logic     reg_write,
  output regaddr_t A3,
  output word_t    WD3,
  output logic     hold_valid,
  output regaddr_t hold_rd
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic held_q, held, starve, collide, b_grant, p_port, cap;
  logic [3:0] starve_cnt;
  wb_req_t hold, s_req;
  assign s_req = '{rd: s_rd, data: s_data};
  wb_hold_buf u_buf (
    .clk,
    .reset,
    .cap,
    .drain(b_grant),
    .cap_req(s_req),
    .hold_valid(held_q),
    .hold
  );
  // grant priority: starvation, same-register ordering, x0 sink, primary, buffer
  always_comb begin
    held = held_q && !reset;
    starve = held && starve_cnt == LIMIT;
    collide = held && p_valid && p_rd == hold.rd;
    p_ready = !reset && p_valid && !starve && !collide;
    b_grant = held && (!p_ready || p_rd == REG_ZERO);
    p_port = p_ready && p_rd != REG_ZERO;
    A3 = p_port ? p_rd : (b_grant ? hold.rd : REG_ZERO);
    WD3 = p_port ? p_data : (b_grant ? hold.data : '0);
    reg_write = (p_port || b_grant) && A3 != REG_ZERO;
    s_ready = !reset && (!held || b_grant);
    cap = s_valid && s_ready;
    hold_valid = held;
    hold_rd = held ? hold.rd : REG_ZERO;
  end
  // cycles the held entry has been denied, saturating at the limit
  always_ff @(posedge clk)
    starve_cnt <= (reset || !held || b_grant) ? '0 :
                  (starve_cnt == LIMIT ? starve_cnt : starve_cnt + 4'd1);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int LIM = 4;
  logic clk = 0, reset = 1;
  logic p_valid = 0, s_valid = 0, p_ready, s_ready, reg_write, hold_valid;
  logic [4:0] p_rd = 0, s_rd = 0, A3, hold_rd;
  logic [31:0] p_data = 0, s_data = 0, WD3;
  int tests = 0, fails = 0;
  regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
    .s_valid(s_valid), .s_rd(s_rd), .s_data(s_data), .s_ready(s_ready),
    .reg_write(reg_write), .A3(A3), .WD3(WD3),
    .hold_valid(hold_valid), .hold_rd(hold_rd)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic sv, input logic [4:0] srd, input logic [31:0] sd);
    @(negedge clk);
    p_valid = pv; p_rd = prd; p_data = pd;
    s_valid = sv; s_rd = srd; s_data = sd;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 5, 32'h1, 1, 6, 32'h2);
      tests++;
      if ({reg_write, p_ready, s_ready, hold_valid, hold_rd} !== 9'd0) begin
        fails++;
        $display("FAIL reset_outputs got %b want 0", {reg_write, p_ready, s_ready, hold_valid, hold_rd});
      end
    end
    idle();
    reset = 0;
    idle();
    tests++;
    if ({hold_valid, reg_write, s_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_release got %b want 001", {hold_valid, reg_write, s_ready});
    end
  endtask
  task automatic test_primary();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tests++;
    if ({reg_write, p_ready, A3, WD3, hold_valid} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL primary_only got we=%b rdy=%b a3=%0d wd3=%h want 1 1 5 deadbeef", reg_write, p_ready, A3, WD3);
    end
    idle();
  endtask
  task automatic test_secondary();
    drive(0, 0, 0, 1, 7, 32'h11);
    tests++;
    if ({s_ready, reg_write, hold_valid} !== 3'b100) begin
      fails++;
      $display("FAIL sec_capture got %b want 100", {s_ready, reg_write, hold_valid});
    end
    idle();
    tests++;
    if ({hold_valid, hold_rd, reg_write, A3, WD3} !== {1'b1, 5'd7, 1'b1, 5'd7, 32'h11}) begin
      fails++;
      $display("FAIL sec_drain got hv=%b hrd=%0d we=%b a3=%0d wd3=%h want 1 7 1 7 11", hold_valid, hold_rd, reg_write, A3, WD3);
    end
    idle();
    tests++;
    if ({hold_valid, reg_write} !== 2'b00) begin
      fails++;
      $display("FAIL sec_empty got %b want 00", {hold_valid, reg_write});
    end
  endtask
  task automatic test_starvation();
    drive(0, 0, 0, 1, 9, 32'h99);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(10 + i), 32'(i), 0, 0, 0);
      tests++;
      if ({p_ready, reg_write, A3, hold_valid} !== {1'b1, 1'b1, 5'(10 + i), 1'b1}) begin
        fails++;
        $display("FAIL starve_primary%0d got rdy=%b we=%b a3=%0d hv=%b want 1 1 %0d 1", i, p_ready, reg_write, A3, hold_valid, 10 + i);
      end
    end
    drive(1, 20, 32'h20, 0, 0, 0);
    tests++;
    if ({p_ready, reg_write, A3, WD3} !== {1'b0, 1'b1, 5'd9, 32'h99}) begin
      fails++;
      $display("FAIL starve_preempt got rdy=%b we=%b a3=%0d wd3=%h want 0 1 9 99", p_ready, reg_write, A3, WD3);
    end
    drive(1, 20, 32'h20, 0, 0, 0);
    tests++;
    if ({p_ready, A3, WD3, hold_valid} !== {1'b1, 5'd20, 32'h20, 1'b0}) begin
      fails++;
      $display("FAIL starve_resume got rdy=%b a3=%0d wd3=%h hv=%b want 1 20 20 0", p_ready, A3, WD3, hold_valid);
    end
    idle();
  endtask
  task automatic test_collision();
    drive(0, 0, 0, 1, 3, 32'hAAAA);
    drive(1, 3, 32'hBBBB, 0, 0, 0);
    tests++;
    if ({p_ready, reg_write, A3, WD3} !== {1'b0, 1'b1, 5'd3, 32'hAAAA}) begin
      fails++;
      $display("FAIL collide_old got rdy=%b we=%b a3=%0d wd3=%h want 0 1 3 aaaa", p_ready, reg_write, A3, WD3);
    end
    drive(1, 3, 32'hBBBB, 0, 0, 0);
    tests++;
    if ({p_ready, reg_write, A3, WD3, hold_valid} !== {1'b1, 1'b1, 5'd3, 32'hBBBB, 1'b0}) begin
      fails++;
      $display("FAIL collide_new got rdy=%b we=%b a3=%0d wd3=%h hv=%b want 1 1 3 bbbb 0", p_ready, reg_write, A3, WD3, hold_valid);
    end
    idle();
  endtask
  task automatic test_x0();
    drive(0, 0, 0, 1, 4, 32'hCCCC);
    drive(1, 0, 32'h1234, 0, 0, 0);
    tests++;
    if ({p_ready, reg_write, A3, WD3} !== {1'b1, 1'b1, 5'd4, 32'hCCCC}) begin
      fails++;
      $display("FAIL x0_primary_held got rdy=%b we=%b a3=%0d wd3=%h want 1 1 4 cccc", p_ready, reg_write, A3, WD3);
    end
    drive(1, 0, 32'h1234, 0, 0, 0);
    tests++;
    if ({p_ready, reg_write, A3, WD3, hold_valid} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0}) begin
      fails++;
      $display("FAIL x0_primary_empty got rdy=%b we=%b a3=%0d wd3=%h hv=%b want 1 0 0 0 0", p_ready, reg_write, A3, WD3, hold_valid);
    end
    drive(0, 0, 0, 1, 0, 32'h5555);
    idle();
    tests++;
    if ({hold_valid, reg_write, A3} !== {1'b1, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL x0_secondary got hv=%b we=%b a3=%0d want 1 0 0", hold_valid, reg_write, A3);
    end
    idle();
  endtask
  task automatic test_back_to_back();
    drive(0, 0, 0, 1, 6, 32'hD);
    drive(0, 0, 0, 1, 8, 32'hE);
    tests++;
    if ({s_ready, reg_write, A3, WD3} !== {1'b1, 1'b1, 5'd6, 32'hD}) begin
      fails++;
      $display("FAIL b2b_swap got srdy=%b we=%b a3=%0d wd3=%h want 1 1 6 d", s_ready, reg_write, A3, WD3);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 5'(16 + i), 32'(100 + i));
      tests++;
      if ({s_ready, hold_rd, A3} !== {1'b1, (i == 0) ? 5'd8 : 5'(15 + i), (i == 0) ? 5'd8 : 5'(15 + i)}) begin
        fails++;
        $display("FAIL b2b_stream%0d got srdy=%b hrd=%0d a3=%0d", i, s_ready, hold_rd, A3);
      end
    end
    idle();
    tests++;
    if ({hold_valid, hold_rd, A3, WD3} !== {1'b1, 5'd19, 5'd19, 32'd103}) begin
      fails++;
      $display("FAIL b2b_last got hv=%b hrd=%0d a3=%0d wd3=%0d want 1 19 19 103", hold_valid, hold_rd, A3, WD3);
    end
    idle();
  endtask
  task automatic test_reset_mid();
    drive(0, 0, 0, 1, 12, 32'hF);
    for (int i = 0; i < 3; i++) drive(1, 5'(20 + i), 32'(i), 0, 0, 0);
    idle();
    reset = 1;
    #1;
    tests++;
    if ({reg_write, hold_valid, hold_rd, s_ready} !== 8'd0) begin
      fails++;
      $display("FAIL midreset_outputs got we=%b hv=%b hrd=%0d srdy=%b want 0", reg_write, hold_valid, hold_rd, s_ready);
    end
    idle();
    reset = 0;
    #1;
    tests++;
    if ({hold_valid, reg_write} !== 2'b00) begin
      fails++;
      $display("FAIL midreset_discard got %b want 00", {hold_valid, reg_write});
    end
    drive(0, 0, 0, 1, 13, 32'h13);
    for (int i = 0; i < 5; i++) begin
      drive(1, 25, 32'h25, 0, 0, 0);
      tests++;
      if (p_ready !== (i < 4)) begin
        fails++;
        $display("FAIL midreset_starve%0d got rdy=%b want %b", i, p_ready, i < 4);
      end
    end
    drive(1, 25, 32'h25, 0, 0, 0);
    idle();
  endtask
  task automatic test_random();
    logic m_held = 0, pv = 0, sv = 0, ex_pacc, ex_sr, ex_we, deny;
    logic [4:0] m_rd = 0, prd = 0, srd = 0, ex_a;
    logic [31:0] m_data = 0, pd = 0, sd = 0, ex_d;
    int m_wait = 0, win;
    for (int n = 0; n < 600; n++) begin
      sv = $urandom_range(0, 1) == 1;
      srd = 5'($urandom_range(0, 7));
      sd = $urandom;
      drive(pv, prd, pd, sv, srd, sd);
      deny = m_held && (m_wait >= LIM || (pv && prd == m_rd));
      win = deny ? 2 : pv ? ((prd == 0) ? (m_held ? 2 : 0) : 1) : (m_held ? 2 : 0);
      ex_pacc = pv && !deny;
      ex_a = (win == 1) ? prd : (win == 2) ? m_rd : 5'd0;
      ex_d = (win == 1) ? pd : (win == 2) ? m_data : 32'd0;
      ex_we = win != 0 && ex_a != 0;
      ex_sr = !m_held || win == 2;
      tests++;
      if ({p_ready, s_ready, reg_write, A3, WD3, hold_valid, hold_rd} !==
          {ex_pacc, ex_sr, ex_we, ex_a, ex_d, m_held, m_held ? m_rd : 5'd0}) begin
        fails++;
        $display("FAIL random%0d got prdy=%b srdy=%b we=%b a3=%0d wd3=%h hv=%b hrd=%0d want %b %b %b %0d %h %b %0d",
                 n, p_ready, s_ready, reg_write, A3, WD3, hold_valid, hold_rd,
                 ex_pacc, ex_sr, ex_we, ex_a, ex_d, m_held, m_held ? m_rd : 5'd0);
      end
      if (sv && ex_sr) begin
        m_held = 1; m_rd = srd; m_data = sd; m_wait = 0;
      end else if (win == 2) begin
        m_held = 0; m_wait = 0;
      end else if (m_held) m_wait++;
      if (!pv || ex_pacc) begin
        pv = $urandom_range(0, 3) != 0;
        prd = 5'($urandom_range(0, 7));
        pd = $urandom;
      end
    end
    idle();
    idle();
  endtask
  initial begin
    test_reset();
    test_primary();
    test_secondary();
    test_starvation();
    test_collision();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
